// File: rtl/tof_pkg.sv
// Shared types and default register map for the multi-sensor ToF poller.
package tof_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SELECT,
        REQ_STATUS,
        WAIT_STATUS,
        REQ_DIST,
        WAIT_DIST,
        PUBLISH,
        RETRY,
        NEXT
    } tof_state_t;

    localparam logic [15:0] DEFAULT_STATUS_REG = 16'h2C00;
    localparam logic [15:0] DEFAULT_DIST_REG   = 16'h2C04;

endpackage

// File: rtl/tof_poll_timer.sv
// Free-running round timer: counts modulo DIV while enabled, parked at 0 otherwise.
module tof_poll_timer #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;
    logic             terminal;

    assign terminal = (count == CNT_W'(DIV - 1));
    assign tick     = en && terminal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!en || terminal) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/tof_multi_poller.sv
// Round-robin poller: per round, reads status then distance from each masked
// ToF sensor over an external I2C master, with bounded retries and sticky errors.
module tof_multi_poller
    import tof_pkg::*;
#(
    parameter int          N_SENSORS  = 4,
    parameter int          DIST_W     = 16,
    parameter int          RETRY_MAX  = 3,
    parameter int          POLL_DIV   = 1000,
    parameter logic [15:0] STATUS_REG = DEFAULT_STATUS_REG,
    parameter logic [15:0] DIST_REG   = DEFAULT_DIST_REG
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [N_SENSORS-1:0]         sensor_mask,
    input  logic                         ready,
    input  logic                         error_in,
    input  logic [7:0]                   rx_data,
    input  logic                         rx_valid,
    output logic                         start,
    output logic [15:0]                  register_address,
    output logic                         is_read,
    output logic [9:0]                   nb_of_bytes,
    output logic [$clog2(N_SENSORS)-1:0] sensor_index,
    output logic [DIST_W-1:0]            distance_data,
    output logic                         distance_valid,
    output logic [N_SENSORS-1:0]         sensor_error,
    output logic                         busy
);

    localparam int IDX_W = $clog2(N_SENSORS);
    localparam int NB    = DIST_W / 8;
    localparam int RC_W  = $clog2(RETRY_MAX + 2);
    localparam int BC_W  = $clog2(NB + 2);

    tof_state_t        state, state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;
    logic [RC_W-1:0]   retry_cnt;
    logic [DIST_W-1:0] shift_reg;
    logic [BC_W-1:0]   byte_cnt;
    logic              fail;
    logic              wait_first;
    logic              tick;
    logic              completing;

    tof_poll_timer #(.DIV(POLL_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (enable),
        .tick  (tick)
    );

    // The master's ready is still stale in the cycle right after start.
    assign completing   = ready && !wait_first;
    assign busy         = (state != IDLE);
    assign sensor_index = idx;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_SENSORS - 1; i >= 0; i--) begin
            if (i >= int'(idx) && sensor_mask[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next       = state;
        start            = 1'b0;
        register_address = '0;
        is_read          = 1'b0;
        nb_of_bytes      = '0;
        distance_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (tick) state_next = SELECT;
            end
            SELECT: begin
                if (!enable || !sel_found) state_next = IDLE;
                else                       state_next = REQ_STATUS;
            end
            REQ_STATUS, WAIT_STATUS: begin
                register_address = STATUS_REG;
                is_read          = 1'b1;
                nb_of_bytes      = 10'd1;
                if (state == REQ_STATUS) begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (ready) begin
                        start      = 1'b1;
                        state_next = WAIT_STATUS;
                    end
                end else if (completing) begin
                    if (!enable)           state_next = IDLE;
                    else if (fail)         state_next = RETRY;
                    else if (shift_reg[0]) state_next = REQ_DIST;
                    else                   state_next = NEXT;
                end
            end
            REQ_DIST, WAIT_DIST: begin
                register_address = DIST_REG;
                is_read          = 1'b1;
                nb_of_bytes      = 10'(NB);
                if (state == REQ_DIST) begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (ready) begin
                        start      = 1'b1;
                        state_next = WAIT_DIST;
                    end
                end else if (completing) begin
                    if (!enable)                          state_next = IDLE;
                    else if (fail || int'(byte_cnt) < NB) state_next = RETRY;
                    else                                  state_next = PUBLISH;
                end
            end
            PUBLISH: begin
                distance_valid = 1'b1;
                state_next     = NEXT;
            end
            RETRY: begin
                if (!enable)                           state_next = IDLE;
                else if (int'(retry_cnt) + 1 <= RETRY_MAX) state_next = REQ_STATUS;
                else                                   state_next = NEXT;
            end
            NEXT: begin
                if (!enable || idx == IDX_W'(N_SENSORS - 1)) state_next = IDLE;
                else                                         state_next = SELECT;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: sensor index, retry bookkeeping, byte capture and published results.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx           <= '0;
            retry_cnt     <= '0;
            shift_reg     <= '0;
            byte_cnt      <= '0;
            fail          <= 1'b0;
            wait_first    <= 1'b0;
            distance_data <= '0;
            sensor_error  <= '0;
        end else begin
            wait_first <= start;
            case (state)
                IDLE: begin
                    if (tick) begin
                        idx       <= '0;
                        retry_cnt <= '0;
                    end
                end
                SELECT: begin
                    if (sel_found) idx <= sel_idx;
                end
                REQ_STATUS, REQ_DIST: begin
                    if (start) begin
                        fail      <= 1'b0;
                        shift_reg <= '0;
                        byte_cnt  <= '0;
                    end
                end
                WAIT_STATUS, WAIT_DIST: begin
                    if (rx_valid) begin
                        shift_reg <= (shift_reg << 8) | DIST_W'(rx_data);
                        if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
                    end
                    if (error_in && !completing) fail <= 1'b1;
                    if (state_next == PUBLISH) distance_data <= shift_reg;
                end
                PUBLISH: begin
                    sensor_error[idx] <= 1'b0;
                    retry_cnt         <= '0;
                end
                RETRY: begin
                    retry_cnt <= retry_cnt + 1'b1;
                    if (state_next == NEXT) sensor_error[idx] <= 1'b1;
                end
                NEXT: begin
                    retry_cnt <= '0;
                    if (state_next == SELECT) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tof_multi_poller.sv
// Scoreboard bench for tof_multi_poller: an I2C master model answers each start,
// a per-round reference model predicts publishes, start counts and error flags.
module tb_tof_multi_poller;

    localparam int          N    = 4;
    localparam int          DW   = 16;
    localparam int          RM   = 3;
    localparam int          PD   = 600;
    localparam logic [15:0] SREG = 16'h2C00;
    localparam logic [15:0] DREG = 16'h2C04;

    logic          clk = 1'b0;
    logic          reset, enable, ready, error_in, rx_valid;
    logic [N-1:0]  sensor_mask;
    logic [7:0]    rx_data;
    logic          start, is_read, distance_valid, busy;
    logic [15:0]   register_address;
    logic [9:0]    nb_of_bytes;
    logic [1:0]    sensor_index;
    logic [DW-1:0] distance_data;
    logic [N-1:0]  sensor_error;

    int errors = 0;
    int checks = 0;

    logic [7:0]    status_cfg [N];
    logic [DW-1:0] dist_cfg   [N];
    bit            fail_cfg   [N];
    bit            short_cfg  [N];
    logic [N-1:0]  exp_err;

    typedef struct {
        int            idx;
        logic [DW-1:0] data;
    } pub_t;
    pub_t exp_q[$];

    int st_cnt, ds_cnt, exp_st, exp_ds;
    bit drop_mode  = 1'b0;
    bit dist2_seen = 1'b0;
    bit drop_done  = 1'b0;

    tof_multi_poller #(
        .N_SENSORS  (N),
        .DIST_W     (DW),
        .RETRY_MAX  (RM),
        .POLL_DIV   (PD),
        .STATUS_REG (SREG),
        .DIST_REG   (DREG)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .sensor_mask      (sensor_mask),
        .ready            (ready),
        .error_in         (error_in),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .start            (start),
        .register_address (register_address),
        .is_read          (is_read),
        .nb_of_bytes      (nb_of_bytes),
        .sensor_index     (sensor_index),
        .distance_data    (distance_data),
        .distance_valid   (distance_valid),
        .sensor_error     (sensor_error),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired", name);
    endtask

    task automatic applyStimulus(input int i, input logic [7:0] st, input logic [DW-1:0] d,
                                 input bit f, input bit s);
        status_cfg[i] = st;
        dist_cfg[i]   = d;
        fail_cfg[i]   = f;
        short_cfg[i]  = s;
    endtask

    // Reference model: outcome of one round straight from the polling rules.
    task automatic buildExpectation(input bit drop);
        pub_t p;
        exp_st = 0;
        exp_ds = 0;
        for (int i = 0; i < N; i++) begin
            if (!sensor_mask[i]) continue;
            if (drop && i == 2) begin
                exp_st += 1;
                exp_ds += 1;
                break;
            end
            if (fail_cfg[i]) begin
                exp_st += RM + 1;
                exp_err[i] = 1'b1;
            end else if (!status_cfg[i][0]) begin
                exp_st += 1;
            end else if (short_cfg[i]) begin
                exp_st += RM + 1;
                exp_ds += RM + 1;
                exp_err[i] = 1'b1;
            end else begin
                exp_st += 1;
                exp_ds += 1;
                exp_err[i] = 1'b0;
                p.idx  = i;
                p.data = dist_cfg[i];
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic runRound(input bit drop);
        int n;
        st_cnt     = 0;
        ds_cnt     = 0;
        drop_mode  = drop;
        dist2_seen = 1'b0;
        drop_done  = 1'b0;
        buildExpectation(drop);
        n = 0;
        while (!busy && n < 2 * PD) begin @(negedge clk); n++; end
        if (!busy) timeoutFail("round_start");
        if (drop) begin
            n = 0;
            while (!dist2_seen && n < 2000) begin @(negedge clk); n++; end
            if (!dist2_seen) timeoutFail("dist2_start");
            enable = 1'b0;
            n = 0;
            while (!drop_done && n < 2000) begin @(negedge clk); n++; end
            if (!drop_done) timeoutFail("dist2_done");
            @(negedge clk);
            checkOutput("busy_after_drop", 32'(busy), 32'd0);
            repeat (50) @(negedge clk);
        end else begin
            n = 0;
            while (busy && n < 2000) begin @(negedge clk); n++; end
            if (busy) timeoutFail("round_end");
        end
        checkOutput("status_starts", st_cnt, exp_st);
        checkOutput("dist_starts", ds_cnt, exp_ds);
        checkOutput("sensor_error", 32'(sensor_error), 32'(exp_err));
        checkOutput("pending_publishes", exp_q.size(), 0);
        exp_q.delete();
        drop_mode = 1'b0;
    endtask

    // I2C master model: answers each start with the configured sensor behaviour.
    initial begin
        ready    = 1'b1;
        error_in = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (start && !reset) begin : txn
                int            i;
                int            nbytes;
                bit            is_dist;
                logic [DW-1:0] d;
                i       = int'(sensor_index);
                is_dist = (register_address == DREG);
                checkOutput("start_is_read", 32'(is_read), 32'd1);
                checkOutput("start_nb_bytes", 32'(nb_of_bytes), is_dist ? DW / 8 : 1);
                checkOutput("start_addr", 32'(register_address == SREG || is_dist), 32'd1);
                if (is_dist) ds_cnt++;
                else         st_cnt++;
                @(posedge clk); #1;
                ready = 1'b0;
                if (is_dist && drop_mode && i == 2) dist2_seen = 1'b1;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                if (!is_dist) begin
                    if (fail_cfg[i]) begin
                        @(posedge clk); #1; error_in = 1'b1;
                        @(posedge clk); #1; error_in = 1'b0;
                    end
                    @(posedge clk); #1; rx_data = status_cfg[i]; rx_valid = 1'b1;
                    @(posedge clk); #1; rx_valid = 1'b0;
                end else begin
                    nbytes = short_cfg[i] ? DW / 8 - 1 : DW / 8;
                    d      = dist_cfg[i];
                    for (int b = 0; b < nbytes; b++) begin
                        @(posedge clk); #1; rx_data = d[DW-1 -: 8]; d = d << 8; rx_valid = 1'b1;
                        @(posedge clk); #1; rx_valid = 1'b0;
                    end
                end
                @(posedge clk); #1;
                ready = 1'b1;
                if (is_dist && drop_mode && i == 2) drop_done = 1'b1;
            end
        end
    end

    // Scoreboard monitor: every publish strobe must match the head of the queue.
    initial begin
        pub_t e;
        forever begin
            @(negedge clk);
            if (distance_valid && !reset) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_publish: index %0d data %0h, expected none",
                             sensor_index, distance_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("pub_index", 32'(sensor_index), e.idx);
                    checkOutput("pub_data", 32'(distance_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        sensor_mask = 4'b1111;
        exp_err     = '0;
        for (int i = 0; i < N; i++) applyStimulus(i, 8'h01, DW'(16'h0100 + i), 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(distance_valid), 32'd0);
        checkOutput("rst_data", 32'(distance_data), 32'd0);
        checkOutput("rst_error", 32'(sensor_error), 32'd0);
        checkOutput("rst_index", 32'(sensor_index), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;

        $display("[TB] round: all sensors healthy");
        runRound(1'b0);

        $display("[TB] round: mask 0101");
        sensor_mask = 4'b0101;
        runRound(1'b0);

        $display("[TB] rounds: randomized");
        for (int r = 0; r < 6; r++) begin
            sensor_mask = N'($urandom_range(0, 15));
            for (int i = 0; i < N; i++)
                applyStimulus(i, 8'($urandom_range(0, 255)), DW'($urandom),
                              ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
            runRound(1'b0);
        end

        $display("[TB] round: enable dropped during sensor 2 distance read");
        sensor_mask = 4'b1111;
        for (int i = 0; i < N; i++) applyStimulus(i, 8'h01, DW'(16'h0A00 + i), 1'b0, 1'b0);
        runRound(1'b1);
        enable = 1'b1;

        $display("[TB] round: sensor 1 fails every transaction");
        for (int i = 0; i < N; i++) applyStimulus(i, 8'h01, DW'(16'h0100 + i), 1'b0, 1'b0);
        fail_cfg[1] = 1'b1;
        runRound(1'b0);

        $display("[TB] round: sensor 1 recovers");
        fail_cfg[1] = 1'b0;
        runRound(1'b0);

        $display("[TB] round: sensor 1 fails, sensor 3 not ready");
        fail_cfg[1]   = 1'b1;
        status_cfg[3] = 8'h00;
        runRound(1'b0);

        $display("[TB] reset in the middle of a round");
        begin : mid_reset
            int n;
            n = 0;
            while (!busy && n < 2 * PD) begin @(negedge clk); n++; end
            if (!busy) timeoutFail("reset_round_start");
            repeat (3) @(negedge clk);
            reset = 1'b1;
            repeat (2) @(negedge clk);
            checkOutput("midrst_busy", 32'(busy), 32'd0);
            checkOutput("midrst_start", 32'(start), 32'd0);
            checkOutput("midrst_error", 32'(sensor_error), 32'd0);
            checkOutput("midrst_data", 32'(distance_data), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tof_multi_poller.md
TOF_MULTI_POLLER -- requirements
Module: tof_multi_poller

Interface
REQ-001 The block SHALL have parameter N_SENSORS, default 4, meaning number of ToF sensors polled (legal range 2..16).
REQ-002 The block SHALL have parameter DIST_W, default 16, meaning distance width in bits (multiple of 8, 8..32).
REQ-003 The block SHALL have parameter RETRY_MAX, default 3, meaning retries after a failed I2C transaction.
REQ-004 The block SHALL have parameter POLL_DIV, default 1000, meaning clk cycles from the start of one round to the start of the next.
REQ-005 The block SHALL have parameters STATUS_REG, default 16'h2C00, and DIST_REG, default 16'h2C04, meaning sensor register addresses.
REQ-006 The block SHALL have these ports, one per line:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  polling enable.
- sensor_mask  in  N_SENSORS  1 = sensor polled.
- ready  in  1  I2C master idle / transaction done.
- error_in  in  1  I2C NACK/error, valid while ready=0.
- rx_data  in  8  read byte from master.
- rx_valid  in  1  one-cycle strobe per read byte.
- start  out  1  one-cycle transaction request.
- register_address  out  16  target register.
- is_read  out  1  1 = read transaction.
- nb_of_bytes  out  10  transaction byte count.
- sensor_index  out  clog2(N_SENSORS)  sensor being addressed or published.
- distance_data  out  DIST_W  last published distance.
- distance_valid  out  1  one-cycle publish strobe.
- sensor_error  out  N_SENSORS  sticky per-sensor failure flags.
- busy  out  1  FSM not in IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, SELECT, REQ_STATUS, WAIT_STATUS, REQ_DIST, WAIT_DIST, PUBLISH, RETRY, NEXT.
REQ-008 The poll timer SHALL count clk cycles modulo POLL_DIV while enable=1 and hold at 0 while enable=0; in IDLE, reaching terminal count with enable=1 SHALL go to SELECT with index 0.
REQ-009 SELECT SHALL advance to the lowest index >= current with sensor_mask=1; if none, go to IDLE.
REQ-010 REQ_x states SHALL hold register_address/is_read/nb_of_bytes stable and pulse start for exactly one cycle when ready=1, else wait.
REQ-011 WAIT_x states SHALL ignore ready in the cycle after start, then complete on the first cycle with ready=1.
REQ-012 Status read: is_read=1, nb_of_bytes=1, STATUS_REG; on completion, bit0=1 goes to REQ_DIST, bit0=0 goes to NEXT with no publish and no error change.
REQ-013 Distance read: is_read=1, nb_of_bytes=DIST_W/8, DIST_REG; bytes arrive MSB first and are shifted into a DIST_W register on each rx_valid.
REQ-014 Fewer than DIST_W/8 rx_valid strobes before completion SHALL be treated as an error.
REQ-015 error_in=1 in any WAIT cycle SHALL latch a failure; completion with failure goes to RETRY.
REQ-016 RETRY SHALL increment the per-sensor retry count and return to REQ_STATUS if count <= RETRY_MAX, else set sensor_error[i] and go to NEXT.
REQ-017 PUBLISH SHALL update distance_data, pulse distance_valid for one cycle with sensor_index=i, clear sensor_error[i] and the retry count, then go to NEXT.
REQ-018 NEXT SHALL clear the retry count and go to SELECT with index i+1, or to IDLE after index N_SENSORS-1 (no wrap within a round).
REQ-019 Deasserting enable mid-round SHALL let the in-flight transaction complete (no new start), then go to IDLE without publishing it.
REQ-020 A timer terminal count arriving while busy=1 SHALL be dropped, not queued.
REQ-021 sensor_mask SHALL be sampled only in SELECT.

Reset
REQ-022 Asynchronous reset SHALL force the FSM to IDLE and clear the timer, index, retry count and shift register.
REQ-023 Reset SHALL drive all outputs to 0, including sensor_error, distance_data, start and busy.
REQ-024 Reset mid-transaction SHALL abandon the transaction, with no recovery attempted.

Structure
REQ-025 A shared package tof_pkg SHALL hold the state enum and the default register-address constants.
REQ-026 The poll timer SHALL be one sub-module, tof_poll_timer, with parameter DIV and ports clk, reset, en and tick.

Verification
REQ-027 Scenario: N=4, mask=4'b1111, all status=0x01, distances 0x0100..0x0103 -> 4 distance_valid pulses, indices 0..3, matching data.
REQ-028 Scenario: mask=4'b0101 -> only indices 0 and 2 published, 2 status and 2 distance starts per round.
REQ-029 Scenario: sensor 1 error_in on every transaction, RETRY_MAX=3 -> 4 status starts for sensor 1, then sensor_error=4'b0010 and sensor 2 proceeds.
REQ-030 Scenario: sensor 1 recovers the next round -> sensor_error[1] cleared at its PUBLISH.
REQ-031 Scenario: sensor 3 status=0x00 -> no publish for index 3 and sensor_error unchanged.
REQ-032 Scenario: enable dropped during WAIT_DIST of sensor 2 -> no further start, no publish, busy=0 after ready=1.
